zero_pad_streamer: RTL and testbench
====================================

Name: zero_pad_streamer

Overview:
- Upstream feeder for the 3x3 kernel window stage.
- Takes an unpadded frame of 64-bit channel vectors (8 channels per beat, channel-fastest, row-major) and emits the 1-pixel zero-padded frame the window stage consumes.
- Output is a beat-aligned data_valid stream with no backpressure; the window stage is programmed with img_width+2.

Parameters:
- DATA_W, 64, vector width; fixed at 8 channels x 8 bits.
- DIM_W, 16, width of the dimension and channel config inputs.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latches config and begins a frame; ignored unless IDLE
- in_channels  in  DIM_W  channel count, multiple of 8
- img_width  in  DIM_W  unpadded width W, in pixels
- img_height  in  DIM_W  unpadded height H, in pixels
- s_data  in  DATA_W  input vector
- s_valid  in  1  input vector valid
- s_ready  out  1  block accepts s_data this cycle
- m_data  out  DATA_W  padded output vector (to window pixel_in)
- m_valid  out  1  output beat valid (to window data_valid)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last output beat

Behaviour:
- Reset (rst=0 at clk edge): state IDLE. m_valid=0, m_data=0, s_ready=0, busy=0, done=0. All counters cleared. Applies mid-frame; the partial frame is abandoned and no done is issued.
- On start in IDLE, latch config:
  - D = in_channels>>3
  - W = img_width
  - H = img_height
  - PW = W+2, as a 17-bit value (no wrap).
- Degenerate config: if D, W or H is 0, go to DONE directly with no output beats.
- States and beat counts:
  - IDLE
  - TOP: PW*D zero beats
  - LEFT: D zero beats
  - DATA: W*D input beats
  - RIGHT: D zero beats
  - BOT: PW*D zero beats
  - DONE: 1 cycle, then IDLE
- Transitions:
  - TOP -> LEFT.
  - LEFT -> DATA -> RIGHT.
  - After RIGHT: row_cnt++. If row_cnt == H, go to BOT; else go to LEFT.
  - BOT -> DONE.
- Zero states (TOP/LEFT/RIGHT/BOT) emit exactly one zero beat per cycle, unconditionally.
- DATA state:
  - s_ready=1 combinationally in DATA only.
  - A beat transfers when s_valid && s_ready. Cycles with s_valid=0 produce no output beat and do not advance the counter.
  - s_ready drops in the same cycle the last DATA beat transfers; excess s_valid is not accepted.
- Output timing:
  - m_data/m_valid are registered: each beat appears 1 cycle after it is generated or accepted.
  - m_data holds its last value when m_valid=0.
- Counters:
  - beat_cnt counts beats within the current segment; 32 bits.
  - Segment length is computed once at start; the product PW*D is held in 32 bits.
  - row_cnt counts completed image rows; DIM_W bits.
- Frame total: exactly (W+2)*(H+2)*D output beats, with W*H*D of them taken from input in order.
- busy: 1 from the cycle after start through the DONE cycle.
- done: asserted in the DONE cycle, which is the cycle after the final m_valid beat is presented.
- Start while busy is ignored; config changes while busy have no effect.
- Consumers ignore in_channels bits [2:0]; they are truncated by the shift.

Test Plan:
- C=8, W=2, H=2, input a,b,c,d with s_valid always high -> m_valid 16 consecutive beats: 0,0,0,0, 0,a,b,0, 0,c,d,0, 0,0,0,0; done pulses 1 cycle after beat 16; busy low afterwards.
- C=16, W=1, H=1, input a0,a1 -> 18 beats: 6 zeros, then 0,0,a0,a1,0,0, then 6 zeros; s_ready high for exactly 2 transfer cycles.
- Same config as the first case with s_valid toggling 1,0,0,1,... -> identical m_data beat sequence (m_valid gaps only inside DATA); no zero beat inserted or duplicated.
- Start pulse mid-frame with different W -> ignored; output matches the original config and beat count is unchanged.
- rst=0 during DATA of row 1 -> next cycle m_valid=0, s_ready=0, busy=0, no done; a subsequent start produces a complete correct frame.
- H=0 (or C=4, giving D=0) with start -> zero output beats; done 1 cycle after busy rises; s_ready never asserted.

Source files
------------

// File: rtl/zero_pad_streamer.sv
// Wraps an unpadded channel-vector frame in a one-pixel border of zero vectors
// so the downstream 3x3 window stage sees a (W+2) x (H+2) frame.
module zero_pad_streamer #(
    parameter int DATA_W = 64,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  in_channels,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_LEFT,
        S_DATA,
        S_RIGHT,
        S_BOT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [DIM_W-1:0]   r_h;
    logic [31:0]        r_d_len;
    logic [31:0]        r_row_len;
    logic [31:0]        r_data_len;
    logic [31:0]        r_beat_cnt;
    logic [DIM_W-1:0]   r_row_cnt;
    logic [DATA_W-1:0]  r_m_data;
    logic               r_m_valid;
    logic               r_busy;
    logic               r_done;

    logic [DIM_W-1:0]   w_d;
    logic [16:0]        w_pw;
    logic               w_degenerate;
    logic [31:0]        w_seg_len;
    logic               w_zero_state;
    logic               w_xfer;
    logic               w_emit;
    logic               w_seg_end;
    logic [DIM_W-1:0]   w_row_next;

    assign w_d          = in_channels >> 3;
    assign w_pw         = {1'b0, img_width} + 17'd2;
    assign w_degenerate = (w_d == '0) || (img_width == '0) || (img_height == '0);

    always_comb begin
        w_seg_len = 32'd1;
        case (r_state)
            S_TOP, S_BOT:     w_seg_len = r_row_len;
            S_LEFT, S_RIGHT:  w_seg_len = r_d_len;
            S_DATA:           w_seg_len = r_data_len;
            default:          w_seg_len = 32'd1;
        endcase
    end

    assign w_zero_state = (r_state == S_TOP) || (r_state == S_LEFT) ||
                          (r_state == S_RIGHT) || (r_state == S_BOT);
    assign s_ready      = (r_state == S_DATA);
    assign w_xfer       = s_ready && s_valid;
    assign w_emit       = w_zero_state || w_xfer;
    assign w_seg_end    = w_emit && (r_beat_cnt == w_seg_len - 32'd1);
    assign w_row_next   = r_row_cnt + DIM_W'(1);

    // done is raised one cycle after DONE so it trails the last registered beat;
    // busy stays high through that done cycle and start is ignored meanwhile.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_h        <= '0;
            r_d_len    <= '0;
            r_row_len  <= '0;
            r_data_len <= '0;
            r_beat_cnt <= '0;
            r_row_cnt  <= '0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_m_valid <= w_emit;
            if (w_xfer) begin
                r_m_data <= s_data;
            end else if (w_emit) begin
                r_m_data <= '0;
            end
            if (w_emit) begin
                r_beat_cnt <= w_seg_end ? 32'd0 : r_beat_cnt + 32'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start && !r_busy) begin
                        r_h        <= img_height;
                        r_d_len    <= 32'(w_d);
                        r_row_len  <= 32'(w_pw) * 32'(w_d);
                        r_data_len <= 32'(img_width) * 32'(w_d);
                        r_beat_cnt <= '0;
                        r_row_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= w_degenerate ? S_DONE : S_TOP;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_TOP: begin
                    if (w_seg_end) r_state <= S_LEFT;
                end
                S_LEFT: begin
                    if (w_seg_end) r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_seg_end) r_state <= S_RIGHT;
                end
                S_RIGHT: begin
                    if (w_seg_end) begin
                        r_row_cnt <= w_row_next;
                        r_state   <= (w_row_next == r_h) ? S_BOT : S_LEFT;
                    end
                end
                S_BOT: begin
                    if (w_seg_end) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_zero_pad_streamer.sv
// Directed self-checking bench for zero_pad_streamer: small frames with
// hand-written expected padded beat sequences.
module tb_zero_pad_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in_channels;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] m_data;
    logic        m_valid;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [63:0] src[$];
    logic [63:0] cap[$];
    logic [63:0] exp_q[$];
    int          sready_cnt;
    int          accepted;
    int          done_cnt;
    int          done_cyc;
    int          last_valid_cyc;
    logic        busy_first;
    logic        busy_after;
    logic        timed_out;

    localparam logic [63:0] A = 64'hA1A2_A3A4_A5A6_A7A8;
    localparam logic [63:0] B = 64'hB1B2_B3B4_B5B6_B7B8;
    localparam logic [63:0] C = 64'hC1C2_C3C4_C5C6_C7C8;
    localparam logic [63:0] D = 64'hD1D2_D3D4_D5D6_D7D8;

    zero_pad_streamer #(.DATA_W(64), .DIM_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_channels(in_channels),
        .img_width  (img_width),
        .img_height (img_height),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame; vpat 0 keeps s_valid high, vpat 1 drives 1,0,0,... ;
    // mid_start_at > 0 pulses start with a different width at that cycle.
    task automatic run_frame(input int ch, input int w, input int h,
                             input int vpat, input int mid_start_at);
        int idx;
        int k;
        cap.delete();
        idx = 0;
        sready_cnt = 0;
        accepted = 0;
        done_cnt = 0;
        done_cyc = -1;
        last_valid_cyc = -1;
        timed_out = 1'b0;
        in_channels = 16'(ch);
        img_width = 16'(w);
        img_height = 16'(h);
        s_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_first = busy;
        k = 1;
        while (1) begin
            if (m_valid) begin
                cap.push_back(m_data);
                last_valid_cyc = k;
            end
            if (done) begin
                done_cnt++;
                done_cyc = k;
                break;
            end
            if (k >= 600) begin
                timed_out = 1'b1;
                break;
            end
            start = (k == mid_start_at);
            if (start) img_width = 16'(w + 5);
            s_valid = (vpat == 0) ? 1'b1 : ((k % 3) == 1);
            s_data = (idx < src.size()) ? src[idx] : 64'hBAD0_BAD0_BAD0_BAD0;
            if (s_ready) sready_cnt++;
            if (s_ready && s_valid) begin
                idx++;
                accepted++;
            end
            tick();
            k++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        img_width = 16'(w);
        tick();
        busy_after = busy;
        if (done) done_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        in_channels = '0;
        img_width = '0;
        img_height = '0;
        tick();
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got=%b want=0", m_valid); end
        checks++; if (m_data !== 64'd0) begin errors++; $display("[TB] FAIL reset_m_data got=%h want=0", m_data); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready got=%b want=0", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic(input string tag, input int vpat, input int mid_start_at);
        src = '{A, B, C, D};
        exp_q = '{64'd0, 64'd0, 64'd0, 64'd0,
                  64'd0, A, B, 64'd0,
                  64'd0, C, D, 64'd0,
                  64'd0, 64'd0, 64'd0, 64'd0};
        run_frame(8, 2, 2, vpat, mid_start_at);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL %s_timeout got=%b want=0", tag, timed_out); end
        checks++; if (cap.size() != 16) begin errors++; $display("[TB] FAIL %s_beat_count got=%0d want=16", tag, cap.size()); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL %s_beat%0d got=%h want=%h", tag, i, cap[i], exp_q[i]);
            end
        end
        checks++; if (done_cyc != last_valid_cyc + 1) begin errors++; $display("[TB] FAIL %s_done_timing got=%0d want=%0d", tag, done_cyc, last_valid_cyc + 1); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL %s_done_pulses got=%0d want=1", tag, done_cnt); end
        checks++; if (busy_first !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy_rise got=%b want=1", tag, busy_first); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_after got=%b want=0", tag, busy_after); end
        checks++; if (accepted != 4) begin errors++; $display("[TB] FAIL %s_accepted got=%0d want=4", tag, accepted); end
    endtask

    task automatic test_multi_channel();
        src = '{A, B};
        exp_q = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                  64'd0, 64'd0, A, B, 64'd0, 64'd0,
                  64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        run_frame(16, 1, 1, 0, 0);
        checks++; if (cap.size() != 18) begin errors++; $display("[TB] FAIL mc_beat_count got=%0d want=18", cap.size()); end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL mc_beat%0d got=%h want=%h", i, cap[i], exp_q[i]);
            end
        end
        checks++; if (sready_cnt != 2) begin errors++; $display("[TB] FAIL mc_s_ready_cycles got=%0d want=2", sready_cnt); end
        checks++; if (done_cyc != last_valid_cyc + 1) begin errors++; $display("[TB] FAIL mc_done_timing got=%0d want=%0d", done_cyc, last_valid_cyc + 1); end
    endtask

    task automatic test_reset_mid_frame();
        int dn;
        int mv;
        int k;
        src = '{A, B, C, D};
        in_channels = 16'd8;
        img_width = 16'd2;
        img_height = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        s_data = A;
        k = 0;
        while (!s_ready && k < 50) begin
            tick();
            k++;
        end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmf_reach_data got=%b want=1", s_ready); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmf_m_valid got=%b want=0", m_valid); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmf_s_ready got=%b want=0", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmf_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rmf_done got=%b want=0", done); end
        dn = 0;
        mv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dn++;
            if (m_valid) mv++;
        end
        checks++; if (dn != 0) begin errors++; $display("[TB] FAIL rmf_no_done got=%0d want=0", dn); end
        checks++; if (mv != 0) begin errors++; $display("[TB] FAIL rmf_idle_beats got=%0d want=0", mv); end
        test_basic("after_reset", 0, 0);
    endtask

    task automatic test_degenerate(input string tag, input int ch, input int w, input int h);
        src.delete();
        run_frame(ch, w, h, 0, 0);
        checks++; if (cap.size() != 0) begin errors++; $display("[TB] FAIL %s_beats got=%0d want=0", tag, cap.size()); end
        checks++; if (busy_first !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy_rise got=%b want=1", tag, busy_first); end
        checks++; if (done_cyc != 2) begin errors++; $display("[TB] FAIL %s_done_cycle got=%0d want=2", tag, done_cyc); end
        checks++; if (sready_cnt != 0) begin errors++; $display("[TB] FAIL %s_s_ready got=%0d want=0", tag, sready_cnt); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_after got=%b want=0", tag, busy_after); end
    endtask

    initial begin
        test_reset();
        test_basic("basic", 0, 0);
        test_multi_channel();
        test_basic("valid_gaps", 1, 0);
        test_basic("mid_start", 0, 5);
        test_reset_mid_frame();
        test_degenerate("h_zero", 8, 2, 0);
        test_degenerate("d_zero", 4, 2, 2);
        test_basic("back_to_back", 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
